// File: rtl/mode_switch_ctrl.sv
// Sequences motor-output handover between the DSHOT and serial passthrough engines.
// Optional passthrough inactivity watchdog is built when MODE_SWITCH_WDOG_EN is defined.
module mode_switch_ctrl #(
  parameter int unsigned DRAIN_TIMEOUT = 100000,
  parameter int unsigned GUARD_CYCLES  = 1000,
  parameter int unsigned WDOG_CYCLES   = 5000000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_req_mode,
  input  logic       i_dshot_busy,
  input  logic       i_serial_busy,
  input  logic       i_serial_act,
  input  logic       i_clr_flags,
  output logic [1:0] o_mode_active,
  output logic       o_dshot_en,
  output logic       o_serial_en,
  output logic       o_pins_idle,
  output logic       o_switching,
  output logic       o_drain_timeout,
  output logic       o_wdog_revert
);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_GUARD  = 2'd2;
  localparam logic [1:0] ST_SWITCH = 2'd3;

  localparam logic [1:0] MODE_DSHOT  = 2'b00;
  localparam logic [1:0] MODE_SERIAL = 2'b01;

  // One counter serves both DRAIN and GUARD, so it is sized for the larger limit.
  localparam int unsigned CNT_MAX = (DRAIN_TIMEOUT > GUARD_CYCLES) ? DRAIN_TIMEOUT : GUARD_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_TIMEOUT - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT    = CW'(CNT_MAX);

  logic [1:0]    state_r, state_s;
  logic [1:0]    target_r, target_s;
  logic [CW-1:0] cnt_r, cnt_s, cnt_inc_s;
  logic [1:0]    mode_active_r, mode_s;
  logic          dshot_en_r, dshot_en_s;
  logic          serial_en_r, serial_en_s;
  logic          pins_idle_r, pins_idle_s;
  logic          switching_r;
  logic          drain_to_r, drain_to_s, drain_to_set_s;
  logic [1:0]    req_n_s, req_eff_s;
  logic          old_busy_s;
  logic          wdog_fire_s;

  assign req_n_s    = (i_req_mode == MODE_SERIAL) ? MODE_SERIAL : MODE_DSHOT;
  assign old_busy_s = (mode_active_r == MODE_SERIAL) ? i_serial_busy : i_dshot_busy;
  assign cnt_inc_s  = (cnt_r == CNT_SAT) ? cnt_r : (cnt_r + CW'(1));

`ifdef MODE_SWITCH_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  localparam logic [WW-1:0] WDOG_LAST = WW'(WDOG_CYCLES - 1);

  logic [WW-1:0] wdog_cnt_r, wdog_cnt_s;
  logic          wdog_lock_r, wdog_lock_s;
  logic          wdog_revert_r;

  // After a revert the serial request is masked until the host drops it back to DSHOT.
  assign req_eff_s   = wdog_lock_r ? MODE_DSHOT : req_n_s;
  assign wdog_fire_s = (state_r == ST_RUN) && (mode_active_r == MODE_SERIAL) &&
                       !i_serial_act && (wdog_cnt_r >= WDOG_LAST);

  // Watchdog counter and revert lock next-state
  always_comb begin
    wdog_cnt_s  = '0;
    wdog_lock_s = wdog_lock_r;
    if ((state_r == ST_RUN) && (state_s == ST_RUN) && (mode_active_r == MODE_SERIAL) && !i_serial_act) begin
      wdog_cnt_s = (wdog_cnt_r >= WDOG_LAST) ? wdog_cnt_r : (wdog_cnt_r + WW'(1));
    end else begin
      wdog_cnt_s = '0;
    end
    if (wdog_fire_s) begin
      wdog_lock_s = 1'b1;
    end else if (req_n_s == MODE_DSHOT) begin
      wdog_lock_s = 1'b0;
    end else begin
      wdog_lock_s = wdog_lock_r;
    end
  end

  // Watchdog registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wdog_cnt_r    <= '0;
      wdog_lock_r   <= 1'b0;
      wdog_revert_r <= 1'b0;
    end else begin
      wdog_cnt_r    <= wdog_cnt_s;
      wdog_lock_r   <= wdog_lock_s;
      wdog_revert_r <= wdog_fire_s;
    end
  end

  assign o_wdog_revert = wdog_revert_r;
`else
  logic unused_wdog_s;

  assign req_eff_s     = req_n_s;
  assign wdog_fire_s   = 1'b0;
  assign unused_wdog_s = i_serial_act & (WDOG_CYCLES != 32'd0);
  assign o_wdog_revert = 1'b0;
`endif

  // Sequencer next-state; engine and pin outputs are registered from the current state
  always_comb begin
    state_s        = state_r;
    target_s       = target_r;
    cnt_s          = cnt_r;
    mode_s         = mode_active_r;
    dshot_en_s     = dshot_en_r;
    serial_en_s    = serial_en_r;
    pins_idle_s    = pins_idle_r;
    drain_to_set_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        dshot_en_s  = (mode_active_r == MODE_DSHOT);
        serial_en_s = (mode_active_r == MODE_SERIAL);
        pins_idle_s = 1'b0;
        if (wdog_fire_s) begin
          target_s = MODE_DSHOT;
          state_s  = ST_DRAIN;
          cnt_s    = '0;
        end else if (req_eff_s != mode_active_r) begin
          target_s = req_eff_s;
          state_s  = ST_DRAIN;
          cnt_s    = '0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        dshot_en_s  = 1'b0;
        serial_en_s = 1'b0;
        pins_idle_s = 1'b0;
        target_s    = req_eff_s;
        if (!old_busy_s) begin
          state_s = ST_GUARD;
          cnt_s   = '0;
        end else if (cnt_r >= DRAIN_LAST) begin
          state_s        = ST_GUARD;
          cnt_s          = '0;
          drain_to_set_s = 1'b1;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_GUARD: begin
        dshot_en_s  = 1'b0;
        serial_en_s = 1'b0;
        pins_idle_s = 1'b1;
        target_s    = req_eff_s;
        if (cnt_r >= GUARD_LAST) begin
          state_s = ST_SWITCH;
          cnt_s   = '0;
        end else begin
          cnt_s = cnt_inc_s;
        end
      end
      ST_SWITCH: begin
        mode_s      = target_r;
        dshot_en_s  = (target_r == MODE_DSHOT);
        serial_en_s = (target_r == MODE_SERIAL);
        pins_idle_s = 1'b0;
        state_s     = ST_RUN;
        cnt_s       = '0;
      end
      default: begin
        state_s     = ST_RUN;
        target_s    = MODE_DSHOT;
        cnt_s       = '0;
        mode_s      = MODE_DSHOT;
        dshot_en_s  = 1'b1;
        serial_en_s = 1'b0;
        pins_idle_s = 1'b0;
      end
    endcase
  end

  // Sticky drain-timeout flag: a new timeout beats a simultaneous clear
  always_comb begin
    if (drain_to_set_s) begin
      drain_to_s = 1'b1;
    end else if (i_clr_flags) begin
      drain_to_s = 1'b0;
    end else begin
      drain_to_s = drain_to_r;
    end
  end

  // Sequencer and output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r       <= ST_RUN;
      target_r      <= MODE_DSHOT;
      cnt_r         <= '0;
      mode_active_r <= MODE_DSHOT;
      dshot_en_r    <= 1'b1;
      serial_en_r   <= 1'b0;
      pins_idle_r   <= 1'b0;
      switching_r   <= 1'b0;
      drain_to_r    <= 1'b0;
    end else begin
      state_r       <= state_s;
      target_r      <= target_s;
      cnt_r         <= cnt_s;
      mode_active_r <= mode_s;
      dshot_en_r    <= dshot_en_s;
      serial_en_r   <= serial_en_s;
      pins_idle_r   <= pins_idle_s;
      switching_r   <= (state_s != ST_RUN);
      drain_to_r    <= drain_to_s;
    end
  end

  assign o_mode_active   = mode_active_r;
  assign o_dshot_en      = dshot_en_r;
  assign o_serial_en     = serial_en_r;
  assign o_pins_idle     = pins_idle_r;
  assign o_switching     = switching_r;
  assign o_drain_timeout = drain_to_r;

endmodule

// File: tb/tb_mode_switch_ctrl.sv
// Scoreboard bench for mode_switch_ctrl: expected output snapshots are queued with a due cycle
// when stimulus is applied and compared when that cycle is reached.
module tb_mode_switch_ctrl;

  localparam int unsigned DT = 8;
  localparam int unsigned GC = 4;
  localparam int unsigned WC = 16;

  // Output vector layout: {mode[1:0], dshot_en, serial_en, pins_idle, switching, drain_to, wdog_revert}
  localparam logic [7:0] M_ALL  = 8'hFF;
  localparam logic [7:0] M_MODE = 8'hC0;
  localparam logic [7:0] M_SEN  = 8'h10;
  localparam logic [7:0] M_SW   = 8'h04;
  localparam logic [7:0] M_WD   = 8'h01;
  localparam logic [7:0] V_RST  = 8'h20;

  typedef struct {
    int         due;
    string      tag;
    logic [7:0] exp;
    logic [7:0] mask;
  } sb_t;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [1:0] i_req_mode;
  logic       i_dshot_busy, i_serial_busy, i_serial_act, i_clr_flags;
  logic [1:0] o_mode_active;
  logic       o_dshot_en, o_serial_en, o_pins_idle, o_switching, o_drain_timeout, o_wdog_revert;
  logic [7:0] obs_s;

  sb_t sbq[$];
  int  cyc = 0;
  int  n_vec = 0;
  int  n_err = 0;
  int  n;

  always #5 i_clk = ~i_clk;

  mode_switch_ctrl #(.DRAIN_TIMEOUT(DT), .GUARD_CYCLES(GC), .WDOG_CYCLES(WC)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_mode(i_req_mode),
    .i_dshot_busy(i_dshot_busy), .i_serial_busy(i_serial_busy),
    .i_serial_act(i_serial_act), .i_clr_flags(i_clr_flags),
    .o_mode_active(o_mode_active), .o_dshot_en(o_dshot_en), .o_serial_en(o_serial_en),
    .o_pins_idle(o_pins_idle), .o_switching(o_switching),
    .o_drain_timeout(o_drain_timeout), .o_wdog_revert(o_wdog_revert)
  );

  assign obs_s = {o_mode_active, o_dshot_en, o_serial_en, o_pins_idle, o_switching,
                  o_drain_timeout, o_wdog_revert};

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int due, input string tag, input logic [7:0] exp, input logic [7:0] mask);
    sb_t e;
    e.due  = due;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sbq.push_back(e);
  endtask

  task automatic service();
    int i = 0;
    while (i < sbq.size()) begin
      if (sbq[i].due <= cyc) begin
        check(sbq[i].tag, obs_s & sbq[i].mask, sbq[i].exp & sbq[i].mask);
        sbq.delete(i);
      end else begin
        i++;
      end
    end
  endtask

  task automatic tick(input int cnt);
    repeat (cnt) begin
      @(posedge i_clk);
      #1;
      cyc++;
      service();
    end
  endtask

  initial begin
    i_rst = 1'b1; i_req_mode = 2'b00; i_dshot_busy = 1'b0; i_serial_busy = 1'b0;
    i_serial_act = 1'b0; i_clr_flags = 1'b0;
    push(cyc + 1, "reset", V_RST, M_ALL);
    tick(3);
    i_rst = 1'b0;
    push(cyc + 1, "reset_idle", V_RST, M_ALL);
    push(cyc + 3, "reset_idle2", V_RST, M_ALL);
    tick(4);

    // DSHOT -> serial, old engine idle: 1 drain + GC guard cycles
    n = cyc + 1; i_req_mode = 2'b01;
    push(n, "t1_req_seen", 8'h24, M_ALL);
    push(n + 1, "t1_en_drop", 8'h04, M_ALL);
    for (int k = 2; k <= 5; k++) push(n + k, "t1_guard", 8'h0C, M_ALL);
    push(n + 6, "t1_serial_on", 8'h50, M_ALL);
    tick(8);

    // serial -> DSHOT, serial engine busy for 3 drain cycles
    i_serial_busy = 1'b1;
    n = cyc + 1; i_req_mode = 2'b00;
    push(n, "t2_req_seen", 8'h54, M_ALL);
    for (int k = 1; k <= 3; k++) push(n + k, "t2_drain", 8'h44, M_ALL);
    for (int k = 4; k <= 7; k++) push(n + k, "t2_guard", 8'h4C, M_ALL);
    push(n + 8, "t2_dshot_on", 8'h20, M_ALL);
    tick(3);
    i_serial_busy = 1'b0;
    tick(8);

    // drain timeout with DSHOT busy stuck, then sticky flag and clear
    i_dshot_busy = 1'b1;
    n = cyc + 1; i_req_mode = 2'b01;
    push(n, "t3_req_seen", 8'h24, M_ALL);
    push(n + 7, "t3_drain_last", 8'h04, M_ALL);
    push(n + 8, "t3_timeout", 8'h06, M_ALL);
    for (int k = 9; k <= 12; k++) push(n + k, "t3_guard", 8'h0E, M_ALL);
    push(n + 13, "t3_sticky", 8'h52, M_ALL);
    tick(14);
    i_dshot_busy = 1'b0; i_clr_flags = 1'b1;
    push(cyc + 1, "t3_clear", 8'h50, M_ALL);
    tick(1);
    i_clr_flags = 1'b0;
    push(cyc + 1, "t3_cleared", 8'h50, M_ALL);
    tick(1);

    // timeout coinciding with a held clear: set wins, cleared the cycle after
    i_serial_busy = 1'b1; i_clr_flags = 1'b1;
    n = cyc + 1; i_req_mode = 2'b00;
    push(n + 7, "t3b_drain_last", 8'h44, M_ALL);
    push(n + 8, "t3b_set_wins", 8'h46, M_ALL);
    push(n + 9, "t3b_then_clear", 8'h4C, M_ALL);
    push(n + 13, "t3b_dshot_on", 8'h20, M_ALL);
    tick(14);
    i_serial_busy = 1'b0; i_clr_flags = 1'b0;

    // request withdrawn during guard: switch completes back to DSHOT, serial never enabled
    n = cyc + 1; i_req_mode = 2'b01;
    for (int k = 0; k <= 8; k++) push(n + k, "t4_no_serial", 8'h00, M_SEN);
    push(n + 5, "t4_guard", 8'h0C, M_ALL);
    push(n + 6, "t4_back_dshot", 8'h20, M_ALL);
    tick(3);
    i_req_mode = 2'b00;
    tick(8);
    n = cyc + 1; i_req_mode = 2'b11;
    for (int k = 0; k <= 3; k++) push(n + k, "t4_req11", 8'h20, M_ALL);
    tick(5);
    n = cyc + 1; i_req_mode = 2'b10;
    for (int k = 0; k <= 3; k++) push(n + k, "t4_req10", 8'h20, M_ALL);
    tick(5);

    // reset asserted mid-guard
    n = cyc + 1; i_req_mode = 2'b01;
    push(n + 2, "t5_in_guard", 8'h0C, M_ALL);
    tick(3);
    i_rst = 1'b1; i_req_mode = 2'b00;
    push(n + 3, "t5_rst_mid", V_RST, M_ALL);
    push(n + 4, "t5_rst_hold", V_RST, M_ALL);
    tick(2);
    i_rst = 1'b0;
    push(cyc + 1, "t5_after", V_RST, M_ALL);
    push(cyc + 2, "t5_after2", V_RST, M_ALL);
    tick(3);

    // serial mode with no passthrough activity
    n = cyc + 1; i_req_mode = 2'b01;
    push(n + 6, "t6_serial_on", 8'h50, M_ALL);
`ifdef MODE_SWITCH_WDOG_EN
    push(n + 21, "t6_pre_revert", 8'h00, M_WD);
    push(n + 22, "t6_revert", 8'h45, M_MODE | M_SW | M_WD);
    push(n + 23, "t6_pulse_end", 8'h00, M_WD);
    push(n + 28, "t6_reverted", 8'h20, M_ALL);
    push(n + 32, "t6_revert_holds", 8'h20, M_ALL);
    tick(34);
    i_req_mode = 2'b00;
    tick(1);
    n = cyc + 1; i_req_mode = 2'b01;
    push(n + 6, "t7_rearmed", 8'h50, M_ALL);
    tick(7);
    for (int k = 0; k < 40; k++) begin
      i_serial_act = (k % 10 == 0);
      push(cyc + 1, "t7_no_revert", 8'h50, M_ALL);
      tick(1);
    end
    i_serial_act = 1'b0;
`else
    push(n + 30, "t6_no_wdog", 8'h50, M_ALL);
    tick(32);
`endif

    check("sb_empty", 8'(sbq.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
